// File: rtl/io_ctrl_if.sv
// CPU-side bus between the processor core and the board I/O controller.
interface io_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_wren;
  logic              cpu_rden;
  logic [DATA_W-1:0] cpu_rdata;
  logic              io_hit;

  modport master (
    output cpu_addr, cpu_wdata, cpu_wren, cpu_rden,
    input  cpu_rdata, io_hit
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_wren, cpu_rden,
    output cpu_rdata, io_hit
  );
endinterface

// File: rtl/io_ctrl.sv
// Board I/O controller: CPU clock-enable generation, memory-mapped hex/LED/button
// registers with sticky press flags, and button-driven CPU reset.
module io_ctrl #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DIGITS   = 4,
  parameter int unsigned       NBTN     = 3,
  parameter int unsigned       PRESCALE = 2500000,
  parameter int unsigned       DEBOUNCE = 65536,
  parameter logic [ADDR_W-1:0] HEX_ADDR = ADDR_W'('hFFFF),
  parameter logic [ADDR_W-1:0] LED_ADDR = ADDR_W'('hFFFE),
  parameter logic [ADDR_W-1:0] BTN_ADDR = ADDR_W'('hFFFD)
) (
  input  logic                  clock,
  input  logic                  reset,
  io_ctrl_if.slave              bus,
  input  logic [NBTN-1:0]       buttons_n,
  input  logic                  step_mode,
  output logic                  cpu_ce,
  output logic                  cpu_rst,
  output logic [DIGITS*4-1:0]   hex_digits,
  output logic [7:0]            leds
);
  localparam int unsigned HEX_W  = DIGITS * 4;
  localparam int unsigned PRE_W  = $clog2(PRESCALE);
  localparam int unsigned DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned FLAG_LSB = 16;

  logic [NBTN-1:0]   r_sync1;
  logic [NBTN-1:0]   r_sync2;
  logic [DB_W-1:0]   r_db_cnt [NBTN];
  logic [NBTN-1:0]   r_level;
  logic [NBTN-1:0]   r_level_d;
  logic [NBTN-1:0]   r_sticky;
  logic [PRE_W-1:0]  r_pre_cnt;
  logic              r_ce;
  logic              r_rst;
  logic [HEX_W-1:0]  r_hex;
  logic [7:0]        r_leds;
  logic [DATA_W-1:0] r_rdata;

  logic [NBTN-1:0]   w_pressed;
  logic [NBTN-1:0]   w_press;
  logic [PRE_W-1:0]  w_pre_next;
  logic              w_hit_hex;
  logic              w_hit_led;
  logic              w_hit_btn;
  logic              w_wr;
  logic              w_rd;
  logic [DATA_W-1:0] w_btn_status;
  logic [DATA_W-1:0] w_rd_mux;
  logic              w_unused_wdata;

  assign w_pressed = ~r_sync2;
  assign w_press   = r_level & ~r_level_d;
  assign w_hit_hex = (bus.cpu_addr == HEX_ADDR);
  assign w_hit_led = (bus.cpu_addr == LED_ADDR);
  assign w_hit_btn = (bus.cpu_addr == BTN_ADDR);
  assign w_wr      = bus.cpu_wren & r_ce;
  assign w_rd      = bus.cpu_rden & r_ce;
  assign w_unused_wdata = ^bus.cpu_wdata;

  assign bus.io_hit    = w_hit_hex | w_hit_led | w_hit_btn;
  assign bus.cpu_rdata = r_rdata;
  assign cpu_ce        = r_ce;
  assign cpu_rst       = r_rst;
  assign hex_digits    = r_hex;
  assign leds          = r_leds;

  // Two-flop synchroniser for the asynchronous raw buttons (idle = released = 1).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= buttons_n;
      r_sync2 <= r_sync1;
    end
  end

  // Per-button debounce: level flips after DEBOUNCE consecutive differing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NBTN; i++) r_db_cnt[i] <= '0;
      r_level   <= '0;
      r_level_d <= '0;
    end else begin
      r_level_d <= r_level;
      for (int i = 0; i < NBTN; i++) begin
        if (w_pressed[i] != r_level[i]) begin
          if (r_db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
            r_db_cnt[i] <= '0;
            r_level[i]  <= ~r_level[i];
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // Prescaler next value: held at 0 in step mode so a switch to run restarts the period.
  always_comb begin
    w_pre_next = '0;
    if (!step_mode && (r_pre_cnt != PRE_W'(PRESCALE - 1))) begin
      w_pre_next = r_pre_cnt + PRE_W'(1);
    end
  end

  // CPU clock-enable: aligned with the last prescaler count, or one pulse per button-2 press.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pre_cnt <= '0;
      r_ce      <= 1'b0;
    end else begin
      r_pre_cnt <= w_pre_next;
      r_ce      <= step_mode ? w_press[2] : (w_pre_next == PRE_W'(PRESCALE - 1));
    end
  end

  // CPU reset line: button 1 asserts (dominant), button 0 releases.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rst <= 1'b1;
    end else if (w_press[1]) begin
      r_rst <= 1'b1;
    end else if (w_press[0]) begin
      r_rst <= 1'b0;
    end
  end

  // Read-data source, taken from register values before this cycle's updates.
  always_comb begin
    w_btn_status = '0;
    w_btn_status[NBTN-1:0] = r_level;
    w_btn_status[FLAG_LSB +: NBTN] = r_sticky;
    w_rd_mux = '0;
    if (w_hit_hex) begin
      w_rd_mux = DATA_W'(r_hex);
    end else if (w_hit_led) begin
      w_rd_mux = DATA_W'(r_leds);
    end else if (w_hit_btn) begin
      w_rd_mux = w_btn_status;
    end
  end

  // Memory-mapped registers; a fresh press survives a same-cycle clearing read.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hex    <= '0;
      r_leds   <= '0;
      r_rdata  <= '0;
      r_sticky <= '0;
    end else begin
      if (w_wr && w_hit_hex) r_hex  <= bus.cpu_wdata[HEX_W-1:0];
      if (w_wr && w_hit_led) r_leds <= bus.cpu_wdata[7:0];
      if (w_rd) r_rdata <= w_rd_mux;
      r_sticky <= (r_sticky & ~{NBTN{w_rd & w_hit_btn}}) | w_press;
    end
  end
endmodule
